rs_issue_queue: RTL and testbench
=================================

Name: rs_issue_queue

Overview:
Parametrised reservation station holding dispatched uOPs until their source physical registers are ready. It selects the oldest ready uOP per functional unit each cycle. The block sits between rename/dispatch and the FU issue ports. Wakeup tags arrive from the writeback broadcast bus.

Parameters:
RS_ENTRIES, 8, number of queue entries (power of two, >= 2)
NUM_FUS, 4, number of functional units / issue ports
NUM_PREGS, 64, physical register count; PREG_W = $clog2(NUM_PREGS)
NUM_WAKEUP, 2, writeback tag broadcasts per cycle
PAYLOAD_W, 32, opaque uOP payload width (opcode, imm, ROB idx)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  discard all entries
disp_valid  in  1  dispatch request
disp_ready  out  1  at least one free entry
disp_fu  in  $clog2(NUM_FUS)  target FU
disp_src1_preg, disp_src2_preg  in  PREG_W each  source tags
disp_src1_rdy, disp_src2_rdy  in  1 each  source already available
disp_dst_preg  in  PREG_W  destination tag
disp_payload  in  PAYLOAD_W  opaque payload
wakeup_valid  in  NUM_WAKEUP  broadcast valid per lane
wakeup_preg  in  NUM_WAKEUP*PREG_W  broadcast tags, lane k at [k*PREG_W +: PREG_W]
fu_ready  in  NUM_FUS  FU f can accept this cycle
issue_valid  out  NUM_FUS  uOP issued to FU f
issue_dst_preg  out  NUM_FUS*PREG_W  issued dest tag per FU
issue_payload  out  NUM_FUS*PAYLOAD_W  issued payload per FU
occupancy  out  $clog2(RS_ENTRIES)+1  valid entry count

Behaviour:
- Entry state: valid, fu, src1/src2 tag+rdy, dst, payload. Age matrix older[i][j] gives relative age.
- Reset: all entries invalid; age matrix cleared; occupancy=0; disp_ready=1; issue_valid=0.
- Dispatch: the transfer occurs when disp_valid && disp_ready. It writes the lowest-index free entry at the clock edge. The new entry is set younger than every currently valid entry.
- disp_ready = (occupancy < RS_ENTRIES), from registered state only. Entries freed by a same-cycle issue are not reusable until the next cycle.
- Wakeup: for each valid entry and each lane k, a wakeup_valid[k] whose tag matches an unready source sets that rdy bit at the edge.
- Dispatch bypass: a wakeup matching a disp source in the same cycle sets that source ready on entry write.
- Eligibility: valid && src1_rdy && src2_rdy.
  - An entry written or woken at edge E is eligible from the cycle after E.
  - Dispatch to issue is at least 1 cycle; wakeup to issue is at least 1 cycle.
- Select, per FU f, combinational from registered state: pick the eligible entry with fu==f that is older than all other eligible entries with fu==f.
- issue_valid[f] = candidate exists && fu_ready[f]. issue_dst_preg and issue_payload are valid only when issue_valid[f]=1 and are don't-care otherwise.
- Deallocation: an entry is cleared at the edge when it issues. Up to NUM_FUS entries are freed per cycle, and an entry issues on at most one port.
- Occupancy: next = occupancy + dispatch_fire − popcount(issue_valid). Dispatch and issue in the same cycle are both applied.
- Flush has priority over dispatch, wakeup and issue. At the edge it invalidates all entries and sets occupancy to 0. issue_valid is still driven combinationally in the flush cycle; the consumer ignores it under flush. A dispatch in a flush cycle is dropped.
- Reset mid-operation behaves as flush plus age matrix clear; there are no partial results.
- No entry starves: once eligible, an entry only waits behind older eligible entries for the same FU.

Test Plan:
- Reset then dispatch one uOP (fu=1, both rdy, dst=5, payload=0xA5) with fu_ready=4'b1111 -> issue_valid=4'b0010 the next cycle, dst=5, payload=0xA5; occupancy 1 then 0.
- Dispatch an entry with src1=12 unready; wakeup lane 1 tag 12 two cycles later -> issue exactly one cycle after the wakeup, not before.
- Dispatch with src2=7 unready and wakeup tag 7 in the same cycle -> entry issues the following cycle (bypass).
- Dispatch A, B, C to fu 0, all ready, with fu_ready[0]=0 for 3 cycles, then 1 -> issue order A, B, C on consecutive cycles; occupancy 3, 2, 1, 0.
- Fill 8 entries with unready sources -> disp_ready=0 and a further disp_valid is not accepted. Then wake one entry and issue it -> disp_ready=1 the cycle after the issue edge.
- 5 valid entries, assert flush together with disp_valid -> occupancy=0, no issue next cycle, and the dispatched uOP is absent.

Source files
------------

// File: rtl/rs_issue_queue.sv
// Reservation station: holds dispatched uOPs until both sources are ready, then issues the
// oldest eligible uOP per functional unit using an age matrix.
module rs_issue_queue #(
  parameter int unsigned RS_ENTRIES = 8,
  parameter int unsigned NUM_FUS    = 4,
  parameter int unsigned NUM_PREGS  = 64,
  parameter int unsigned NUM_WAKEUP = 2,
  parameter int unsigned PAYLOAD_W  = 32,
  localparam int unsigned PREG_W    = $clog2(NUM_PREGS),
  localparam int unsigned FU_W      = (NUM_FUS > 1) ? $clog2(NUM_FUS) : 1,
  localparam int unsigned OCC_W     = $clog2(RS_ENTRIES) + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          disp_valid,
  output logic                          disp_ready,
  input  logic [FU_W-1:0]               disp_fu,
  input  logic [PREG_W-1:0]             disp_src1_preg,
  input  logic [PREG_W-1:0]             disp_src2_preg,
  input  logic                          disp_src1_rdy,
  input  logic                          disp_src2_rdy,
  input  logic [PREG_W-1:0]             disp_dst_preg,
  input  logic [PAYLOAD_W-1:0]          disp_payload,
  input  logic [NUM_WAKEUP-1:0]         wakeup_valid,
  input  logic [NUM_WAKEUP*PREG_W-1:0]  wakeup_preg,
  input  logic [NUM_FUS-1:0]            fu_ready,
  output logic [NUM_FUS-1:0]            issue_valid,
  output logic [NUM_FUS*PREG_W-1:0]     issue_dst_preg,
  output logic [NUM_FUS*PAYLOAD_W-1:0]  issue_payload,
  output logic [OCC_W-1:0]              occupancy
);

  localparam int unsigned IDX_W = $clog2(RS_ENTRIES);

  logic [RS_ENTRIES-1:0] valid_q, valid_d;
  logic [RS_ENTRIES-1:0] src1_rdy_q, src1_rdy_d, src2_rdy_q, src2_rdy_d;
  logic [FU_W-1:0]       fu_q [RS_ENTRIES];
  logic [FU_W-1:0]       fu_d [RS_ENTRIES];
  logic [PREG_W-1:0]     src1_q [RS_ENTRIES];
  logic [PREG_W-1:0]     src1_d [RS_ENTRIES];
  logic [PREG_W-1:0]     src2_q [RS_ENTRIES];
  logic [PREG_W-1:0]     src2_d [RS_ENTRIES];
  logic [PREG_W-1:0]     dst_q [RS_ENTRIES];
  logic [PREG_W-1:0]     dst_d [RS_ENTRIES];
  logic [PAYLOAD_W-1:0]  payload_q [RS_ENTRIES];
  logic [PAYLOAD_W-1:0]  payload_d [RS_ENTRIES];
  // older_q[i][j] set means entry i was dispatched before entry j
  logic [RS_ENTRIES-1:0] older_q [RS_ENTRIES];
  logic [RS_ENTRIES-1:0] older_d [RS_ENTRIES];
  logic [OCC_W-1:0]      occupancy_q, occupancy_d;

  logic [RS_ENTRIES-1:0] elig;
  logic [RS_ENTRIES-1:0] req [NUM_FUS];
  logic [RS_ENTRIES-1:0] grant [NUM_FUS];
  logic [RS_ENTRIES-1:0] issue_fire;
  logic                  blocked;
  logic [IDX_W-1:0]      free_idx;
  logic                  free_found;
  logic                  disp_fire;
  logic [OCC_W-1:0]      issue_cnt;

  assign occupancy  = occupancy_q;
  assign disp_ready = (occupancy_q < OCC_W'(RS_ENTRIES));
  assign disp_fire  = disp_valid && disp_ready;

  always_comb begin
    free_idx   = '0;
    free_found = 1'b0;
    for (int i = 0; i < RS_ENTRIES; i++) begin
      if (!valid_q[i] && !free_found) begin
        free_idx   = IDX_W'(i);
        free_found = 1'b1;
      end
    end
  end

  // Oldest-first select per FU: an entry wins if no older requester targets the same FU.
  always_comb begin
    issue_fire     = '0;
    issue_valid    = '0;
    issue_dst_preg = '0;
    issue_payload  = '0;
    blocked        = 1'b0;
    for (int i = 0; i < RS_ENTRIES; i++) begin
      elig[i] = valid_q[i] & src1_rdy_q[i] & src2_rdy_q[i];
    end
    for (int f = 0; f < NUM_FUS; f++) begin
      req[f]   = '0;
      grant[f] = '0;
      for (int i = 0; i < RS_ENTRIES; i++) begin
        req[f][i] = elig[i] && (fu_q[i] == FU_W'(f));
      end
      for (int i = 0; i < RS_ENTRIES; i++) begin
        blocked = 1'b0;
        for (int j = 0; j < RS_ENTRIES; j++) begin
          if (req[f][j] && older_q[j][i]) blocked = 1'b1;
        end
        grant[f][i] = req[f][i] & ~blocked;
        if (grant[f][i]) begin
          issue_dst_preg[f*PREG_W +: PREG_W]   = dst_q[i];
          issue_payload[f*PAYLOAD_W +: PAYLOAD_W] = payload_q[i];
        end
      end
      issue_valid[f] = (|grant[f]) & fu_ready[f];
      if (fu_ready[f]) issue_fire = issue_fire | grant[f];
    end
  end

  always_comb begin
    issue_cnt = '0;
    for (int f = 0; f < NUM_FUS; f++) begin
      issue_cnt = issue_cnt + OCC_W'(issue_valid[f]);
    end
  end

  always_comb begin
    valid_d     = valid_q & ~issue_fire;
    src1_rdy_d  = src1_rdy_q;
    src2_rdy_d  = src2_rdy_q;
    fu_d        = fu_q;
    src1_d      = src1_q;
    src2_d      = src2_q;
    dst_d       = dst_q;
    payload_d   = payload_q;
    older_d     = older_q;
    occupancy_d = occupancy_q + OCC_W'(disp_fire) - issue_cnt;

    for (int i = 0; i < RS_ENTRIES; i++) begin
      for (int k = 0; k < NUM_WAKEUP; k++) begin
        if (valid_q[i] && wakeup_valid[k]) begin
          if (wakeup_preg[k*PREG_W +: PREG_W] == src1_q[i]) src1_rdy_d[i] = 1'b1;
          if (wakeup_preg[k*PREG_W +: PREG_W] == src2_q[i]) src2_rdy_d[i] = 1'b1;
        end
      end
    end

    if (disp_fire) begin
      valid_d[free_idx]    = 1'b1;
      fu_d[free_idx]       = disp_fu;
      src1_d[free_idx]     = disp_src1_preg;
      src2_d[free_idx]     = disp_src2_preg;
      dst_d[free_idx]      = disp_dst_preg;
      payload_d[free_idx]  = disp_payload;
      src1_rdy_d[free_idx] = disp_src1_rdy;
      src2_rdy_d[free_idx] = disp_src2_rdy;
      // Same-cycle writeback bypass into the new entry
      for (int k = 0; k < NUM_WAKEUP; k++) begin
        if (wakeup_valid[k] && wakeup_preg[k*PREG_W +: PREG_W] == disp_src1_preg)
          src1_rdy_d[free_idx] = 1'b1;
        if (wakeup_valid[k] && wakeup_preg[k*PREG_W +: PREG_W] == disp_src2_preg)
          src2_rdy_d[free_idx] = 1'b1;
      end
      older_d[free_idx] = '0;
      for (int j = 0; j < RS_ENTRIES; j++) begin
        older_d[j][free_idx] = valid_q[j];
      end
    end

    if (flush) begin
      valid_d     = '0;
      occupancy_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= '0;
      occupancy_q <= '0;
      for (int i = 0; i < RS_ENTRIES; i++) older_q[i] <= '0;
    end else begin
      valid_q     <= valid_d;
      occupancy_q <= occupancy_d;
      older_q     <= older_d;
    end
    src1_rdy_q <= src1_rdy_d;
    src2_rdy_q <= src2_rdy_d;
    fu_q       <= fu_d;
    src1_q     <= src1_d;
    src2_q     <= src2_d;
    dst_q      <= dst_d;
    payload_q  <= payload_d;
  end

endmodule

// File: tb/tb_rs_issue_queue.sv
// Directed bench for rs_issue_queue: expected issues go into a scoreboard queue that a
// negedge monitor drains; status outputs are checked inline by the stimulus.
module tb_rs_issue_queue;

  logic        clk = 1'b0;
  logic        rst, flush, disp_valid, disp_ready;
  logic [1:0]  disp_fu;
  logic [5:0]  disp_src1_preg, disp_src2_preg, disp_dst_preg;
  logic        disp_src1_rdy, disp_src2_rdy;
  logic [31:0] disp_payload;
  logic [1:0]  wakeup_valid;
  logic [11:0] wakeup_preg;
  logic [3:0]  fu_ready, issue_valid;
  logic [23:0] issue_dst_preg;
  logic [127:0] issue_payload;
  logic [3:0]  occupancy;

  typedef struct {
    int          cyc;
    int          fu;
    logic [5:0]  dst;
    logic [31:0] pl;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  rs_issue_queue dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_fu(disp_fu),
    .disp_src1_preg(disp_src1_preg), .disp_src2_preg(disp_src2_preg),
    .disp_src1_rdy(disp_src1_rdy), .disp_src2_rdy(disp_src2_rdy),
    .disp_dst_preg(disp_dst_preg), .disp_payload(disp_payload),
    .wakeup_valid(wakeup_valid), .wakeup_preg(wakeup_preg), .fu_ready(fu_ready),
    .issue_valid(issue_valid), .issue_dst_preg(issue_dst_preg),
    .issue_payload(issue_payload), .occupancy(occupancy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every observed issue must match the next expected record exactly.
  always @(negedge clk) begin
    if (!rst && !flush) begin
      for (int f = 0; f < 4; f++) begin
        if (issue_valid[f]) begin
          n_cmp++;
          if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_issue: cycle %0d fu %0d dst %0d payload %0h, none expected",
                     cyc, f, issue_dst_preg[f*6 +: 6], issue_payload[f*32 +: 32]);
          end else begin
            exp_t e;
            e = sb.pop_front();
            if (e.cyc != cyc || e.fu != f || e.dst !== issue_dst_preg[f*6 +: 6] ||
                e.pl !== issue_payload[f*32 +: 32]) begin
              n_fail++;
              $display("FAIL issue: got cycle %0d fu %0d dst %0d payload %0h, expected cycle %0d fu %0d dst %0d payload %0h",
                       cyc, f, issue_dst_preg[f*6 +: 6], issue_payload[f*32 +: 32],
                       e.cyc, e.fu, e.dst, e.pl);
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_issue(input int c, input int fu, input int dst, input int pl);
    exp_t e;
    e.cyc = c;
    e.fu  = fu;
    e.dst = 6'(dst);
    e.pl  = 32'(pl);
    sb.push_back(e);
  endtask

  task automatic disp_set(input int fu, input int s1, input bit r1, input int s2, input bit r2,
                          input int dst, input int pl);
    disp_valid     = 1'b1;
    disp_fu        = 2'(fu);
    disp_src1_preg = 6'(s1);
    disp_src1_rdy  = r1;
    disp_src2_preg = 6'(s2);
    disp_src2_rdy  = r2;
    disp_dst_preg  = 6'(dst);
    disp_payload   = 32'(pl);
  endtask

  task automatic disp_clr();
    disp_valid = 1'b0;
  endtask

  task automatic wake(input int lane, input int tag);
    wakeup_valid[lane]         = 1'b1;
    wakeup_preg[lane*6 +: 6]   = 6'(tag);
  endtask

  task automatic wake_clr();
    wakeup_valid = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; fu_ready = 4'hF;
    disp_valid = 1'b0; disp_fu = '0; disp_src1_preg = '0; disp_src2_preg = '0;
    disp_src1_rdy = 1'b0; disp_src2_rdy = 1'b0; disp_dst_preg = '0; disp_payload = '0;
    wakeup_valid = '0; wakeup_preg = '0;
    tick(); tick();
    rst = 1'b0;
    chk("reset_occupancy", 32'(occupancy), 0);
    chk("reset_disp_ready", 32'(disp_ready), 1);
    chk("reset_issue_valid", 32'(issue_valid), 0);

    // Single ready uOP issues the cycle after dispatch
    disp_set(1, 0, 1, 0, 1, 5, 'hA5);
    expect_issue(cyc + 1, 1, 5, 'hA5);
    tick(); disp_clr();
    chk("single_occ_1", 32'(occupancy), 1);
    chk("single_issue_valid", 32'(issue_valid), 32'b0010);
    tick();
    chk("single_occ_0", 32'(occupancy), 0);

    // Late wakeup on lane 1; a non-matching tag on lane 0 must not wake it
    disp_set(2, 12, 0, 3, 1, 20, 'h222);
    tick(); disp_clr();
    wake(0, 13);
    tick(); wake_clr();
    chk("wakeup_no_early_issue", 32'(issue_valid), 0);
    wake(1, 12);
    expect_issue(cyc + 1, 2, 20, 'h222);
    tick(); wake_clr();
    chk("wakeup_issue_valid", 32'(issue_valid), 32'b0100);
    tick();

    // Dispatch bypass: wakeup in the same cycle as dispatch
    disp_set(3, 1, 1, 7, 0, 30, 'h333);
    wake(0, 7);
    expect_issue(cyc + 1, 3, 30, 'h333);
    tick(); disp_clr(); wake_clr();
    chk("bypass_issue_valid", 32'(issue_valid), 32'b1000);
    tick();

    // Age order on a stalled FU
    fu_ready = 4'b1110;
    disp_set(0, 0, 1, 0, 1, 10, 'hAAA); tick();
    disp_set(0, 0, 1, 0, 1, 11, 'hBBB); tick();
    disp_set(0, 0, 1, 0, 1, 12, 'hCCC); tick();
    disp_clr();
    fu_ready = 4'hF;
    expect_issue(cyc,     0, 10, 'hAAA);
    expect_issue(cyc + 1, 0, 11, 'hBBB);
    expect_issue(cyc + 2, 0, 12, 'hCCC);
    chk("age_occ_3", 32'(occupancy), 3);
    tick(); chk("age_occ_2", 32'(occupancy), 2);
    tick(); chk("age_occ_1", 32'(occupancy), 1);
    tick(); chk("age_occ_0", 32'(occupancy), 0);

    // Fill to capacity with unready uOPs
    for (int i = 0; i < 8; i++) begin
      disp_set(i % 4, 40 + i, 0, 0, 1, i, 'h500 + i);
      tick();
    end
    disp_clr();
    chk("full_occ", 32'(occupancy), 8);
    chk("full_disp_ready", 32'(disp_ready), 0);
    disp_set(0, 0, 1, 0, 1, 63, 'hBAD);
    tick(); disp_clr();
    chk("full_reject_occ", 32'(occupancy), 8);
    wake(0, 43);
    expect_issue(cyc + 1, 3, 3, 'h503);
    tick(); wake_clr();
    chk("full_ready_during_issue", 32'(disp_ready), 0);
    chk("full_issue_valid", 32'(issue_valid), 32'b1000);
    tick();
    chk("full_ready_after_issue", 32'(disp_ready), 1);
    chk("full_occ_after_issue", 32'(occupancy), 7);

    // Flush clears everything, including a dispatch in the flush cycle
    flush = 1'b1;
    tick(); flush = 1'b0;
    chk("flush_clear_occ", 32'(occupancy), 0);
    for (int i = 0; i < 5; i++) begin
      disp_set(i % 4, 40 + i, 0, 0, 1, 20 + i, 'h600 + i);
      tick();
    end
    disp_clr();
    chk("pre_flush_occ", 32'(occupancy), 5);
    flush = 1'b1;
    disp_set(0, 0, 1, 0, 1, 50, 'hF00);
    tick(); flush = 1'b0; disp_clr();
    chk("flush_occ", 32'(occupancy), 0);
    chk("flush_no_issue", 32'(issue_valid), 0);
    wake(0, 40); wake(1, 41);
    tick();
    wake(0, 42); wake(1, 43);
    tick(); wake_clr();
    chk("flush_entries_gone", 32'(issue_valid), 0);
    tick();
    chk("flush_occ_stays_0", 32'(occupancy), 0);

    // Reset mid-operation, then normal function resumes
    disp_set(1, 60, 0, 0, 1, 1, 'h700); tick();
    disp_set(1, 61, 0, 0, 1, 2, 'h701); tick();
    disp_clr();
    chk("pre_reset_occ", 32'(occupancy), 2);
    rst = 1'b1;
    tick(); rst = 1'b0;
    chk("midreset_occ", 32'(occupancy), 0);
    chk("midreset_disp_ready", 32'(disp_ready), 1);
    disp_set(2, 0, 1, 0, 1, 9, 'h999);
    expect_issue(cyc + 1, 2, 9, 'h999);
    tick(); disp_clr();
    tick(); tick();

    chk("scoreboard_drained", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
